id_ex_stage: RTL and testbench

- ID/EX pipeline register plus EX-side operand forwarding and selection for the 5-stage RV32 core.
- Captures decoded fields from ID, then drives the ALU's A, B and ALUOp inputs.
- Handles stall, flush, load-use bubble insertion, and MEM/WB result forwarding.
- Also supplies the forwarded rs2 value as store data to the MEM stage.

---
 rtl/pipe_pkg.sv | 31 +++
 rtl/fwd_mux.sv | 27 ++
 rtl/id_ex_stage.sv | 215 +++++++++++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and constants for the RV32 pipeline ID/EX slice.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int RIDX_W = 5;

  localparam logic [4:0] ALU_NOP   = 5'd0;
  localparam logic [4:0] ALU_LUI   = 5'd1;
  localparam logic [4:0] ALU_AUIPC = 5'd2;
  localparam logic [4:0] ALU_ADD   = 5'd3;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'd0,
    ASEL_PC   = 2'd1,
    ASEL_ZERO = 2'd2,
    ASEL_RSVD = 2'd3
  } asel_e;

  typedef enum logic {
    BSEL_RS2 = 1'b0,
    BSEL_IMM = 1'b1
  } bsel_e;

  // A producer only matches when it writes a real register (never x0).
  function automatic logic fwd_hit(input logic we,
                                   input logic [RIDX_W-1:0] rd,
                                   input logic [RIDX_W-1:0] rs);
    return we && (rd != '0) && (rd == rs);
  endfunction

endpackage

// File: rtl/fwd_mux.sv
// Priority forwarding for one EX operand: MEM result, then WB result, then register data.
module fwd_mux #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int RIDX_W = pipe_pkg::RIDX_W
) (
  input  logic [RIDX_W-1:0] rs,
  input  logic [XLEN-1:0]   reg_data,
  input  logic              mem_regwrite,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_regwrite,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic [XLEN-1:0]   fwd_data
);
  import pipe_pkg::*;

  always_comb begin
    fwd_data = reg_data;
    if (fwd_hit(mem_regwrite, mem_rd, rs)) begin
      fwd_data = mem_result;
    end else if (fwd_hit(wb_regwrite, wb_rd, rs)) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX-side forwarding, operand select and load-use detection.
// Optional performance counters are enabled by defining ID_EX_PERF_EN.
module id_ex_stage #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int RIDX_W = pipe_pkg::RIDX_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_aluop,
  input  logic [1:0]        id_asel,
  input  logic              id_bsel,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              stall,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic [XLEN-1:0]   mem_result,
  input  logic              wb_regwrite,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_result,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_A,
  output logic [XLEN-1:0]   ex_B,
  output logic [4:0]        ex_aluop,
  output logic [RIDX_W-1:0] ex_rd,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic [XLEN-1:0]   ex_store_data,
  output logic              load_use_hazard
`ifdef ID_EX_PERF_EN
  , output logic [31:0]     perf_stall_cnt
  , output logic [31:0]     perf_bubble_cnt
  , output logic [31:0]     perf_fwd_cnt
`endif
);
  import pipe_pkg::*;

  logic              valid_reg,    valid_next;
  logic [XLEN-1:0]   pc_reg,       pc_next;
  logic [XLEN-1:0]   imm_reg,      imm_next;
  logic [RIDX_W-1:0] rd_reg,       rd_next;
  logic [4:0]        aluop_reg,    aluop_next;
  asel_e             asel_reg,     asel_next;
  bsel_e             bsel_reg,     bsel_next;
  logic              regwrite_reg, regwrite_next;
  logic              memread_reg,  memread_next;
  logic [RIDX_W-1:0] rs_reg   [2];
  logic [RIDX_W-1:0] rs_next  [2];
  logic [XLEN-1:0]   data_reg [2];
  logic [XLEN-1:0]   data_next[2];

  logic [RIDX_W-1:0] id_rs    [2];
  logic [XLEN-1:0]   id_data  [2];
  logic [XLEN-1:0]   cap_data [2];
  logic [XLEN-1:0]   fwd_data [2];
  logic              bubble;

  assign id_rs[0]   = id_rs1;
  assign id_rs[1]   = id_rs2;
  assign id_data[0] = id_rs1_data;
  assign id_data[1] = id_rs2_data;

  for (genvar gi = 0; gi < 2; gi++) begin : g_opnd
    // WB writes the register file this same edge, so the read data is stale.
    assign cap_data[gi] = fwd_hit(wb_regwrite, wb_rd, id_rs[gi]) ? wb_result : id_data[gi];

    fwd_mux #(
      .XLEN   (XLEN),
      .RIDX_W (RIDX_W)
    ) u_fwd (
      .rs           (rs_reg[gi]),
      .reg_data     (data_reg[gi]),
      .mem_regwrite (mem_regwrite),
      .mem_rd       (mem_rd),
      .mem_result   (mem_result),
      .wb_regwrite  (wb_regwrite),
      .wb_rd        (wb_rd),
      .wb_result    (wb_result),
      .fwd_data     (fwd_data[gi])
    );
  end

  assign load_use_hazard = valid_reg && memread_reg && (rd_reg != '0) && id_valid &&
                           ((rd_reg == id_rs1) || (rd_reg == id_rs2));

  assign bubble = flush || (!stall && load_use_hazard);

  always_comb begin
    valid_next    = valid_reg;
    pc_next       = pc_reg;
    imm_next      = imm_reg;
    rd_next       = rd_reg;
    aluop_next    = aluop_reg;
    asel_next     = asel_reg;
    bsel_next     = bsel_reg;
    regwrite_next = regwrite_reg;
    memread_next  = memread_reg;
    for (int i = 0; i < 2; i++) begin
      rs_next[i]   = rs_reg[i];
      data_next[i] = data_reg[i];
    end

    if (bubble) begin
      valid_next    = 1'b0;
      aluop_next    = ALU_NOP;
      regwrite_next = 1'b0;
      memread_next  = 1'b0;
    end else if (stall) begin
      // Refresh held operands so a producer retiring during the stall is not lost.
      for (int i = 0; i < 2; i++) begin
        data_next[i] = fwd_data[i];
      end
    end else begin
      valid_next    = id_valid;
      pc_next       = id_pc;
      imm_next      = id_imm;
      rd_next       = id_rd;
      asel_next     = asel_e'(id_asel);
      bsel_next     = bsel_e'(id_bsel);
      aluop_next    = id_valid ? id_aluop : ALU_NOP;
      regwrite_next = id_valid && id_regwrite;
      memread_next  = id_valid && id_memread;
      for (int i = 0; i < 2; i++) begin
        rs_next[i]   = id_rs[i];
        data_next[i] = cap_data[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_reg    <= 1'b0;
      pc_reg       <= '0;
      imm_reg      <= '0;
      rd_reg       <= '0;
      aluop_reg    <= ALU_NOP;
      asel_reg     <= ASEL_RS1;
      bsel_reg     <= BSEL_RS2;
      regwrite_reg <= 1'b0;
      memread_reg  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        rs_reg[i]   <= '0;
        data_reg[i] <= '0;
      end
    end else begin
      valid_reg    <= valid_next;
      pc_reg       <= pc_next;
      imm_reg      <= imm_next;
      rd_reg       <= rd_next;
      aluop_reg    <= aluop_next;
      asel_reg     <= asel_next;
      bsel_reg     <= bsel_next;
      regwrite_reg <= regwrite_next;
      memread_reg  <= memread_next;
      for (int i = 0; i < 2; i++) begin
        rs_reg[i]   <= rs_next[i];
        data_reg[i] <= data_next[i];
      end
    end
  end

  always_comb begin
    case (asel_reg)
      ASEL_RS1: ex_A = fwd_data[0];
      ASEL_PC:  ex_A = pc_reg;
      default:  ex_A = '0;
    endcase
  end

  assign ex_B          = (bsel_reg == BSEL_IMM) ? imm_reg : fwd_data[1];
  assign ex_store_data = fwd_data[1];
  assign ex_valid      = valid_reg;
  assign ex_aluop      = aluop_reg;
  assign ex_rd         = rd_reg;
  assign ex_regwrite   = regwrite_reg;
  assign ex_memread    = memread_reg;

`ifdef ID_EX_PERF_EN
  logic [31:0] stall_cnt_reg;
  logic [31:0] bubble_cnt_reg;
  logic [31:0] fwd_cnt_reg;
  logic        any_fwd;

  assign any_fwd = fwd_hit(mem_regwrite, mem_rd, rs_reg[0]) ||
                   fwd_hit(wb_regwrite,  wb_rd,  rs_reg[0]) ||
                   fwd_hit(mem_regwrite, mem_rd, rs_reg[1]) ||
                   fwd_hit(wb_regwrite,  wb_rd,  rs_reg[1]);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt_reg  <= '0;
      bubble_cnt_reg <= '0;
      fwd_cnt_reg    <= '0;
    end else begin
      if (stall && !flush) stall_cnt_reg  <= stall_cnt_reg + 32'd1;
      if (bubble)          bubble_cnt_reg <= bubble_cnt_reg + 32'd1;
      if (valid_reg && any_fwd) fwd_cnt_reg <= fwd_cnt_reg + 32'd1;
    end
  end

  assign perf_stall_cnt  = stall_cnt_reg;
  assign perf_bubble_cnt = bubble_cnt_reg;
  assign perf_fwd_cnt    = fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_id_ex_stage;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd, id_aluop;
  logic [1:0]  id_asel;
  logic        id_bsel, id_regwrite, id_memread;
  logic        stall, flush;
  logic        mem_regwrite, wb_regwrite;
  logic [4:0]  mem_rd, wb_rd;
  logic [31:0] mem_result, wb_result;
  logic        ex_valid, ex_regwrite, ex_memread, load_use_hazard;
  logic [31:0] ex_A, ex_B, ex_store_data;
  logic [4:0]  ex_aluop, ex_rd;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_stall_cnt, perf_bubble_cnt, perf_fwd_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rstn(rstn), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_aluop(id_aluop), .id_asel(id_asel), .id_bsel(id_bsel),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .stall(stall), .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_valid(ex_valid), .ex_A(ex_A), .ex_B(ex_B), .ex_aluop(ex_aluop),
    .ex_rd(ex_rd), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_store_data(ex_store_data), .load_use_hazard(load_use_hazard)
`ifdef ID_EX_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bubble_cnt(perf_bubble_cnt)
    , .perf_fwd_cnt(perf_fwd_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural view of the instruction sitting in EX.
  logic        m_init = 1'b0;
  logic        m_known;
  logic        m_valid, m_rw, m_mr, m_bsel;
  logic [1:0]  m_asel;
  logic [4:0]  m_rs1, m_rs2, m_rd, m_aluop;
  logic [31:0] m_pc, m_imm, m_d1, m_d2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] m_fwd(input logic [4:0] rs, input logic [31:0] d);
    if (mem_regwrite && mem_rd != 0 && mem_rd == rs) return mem_result;
    if (wb_regwrite && wb_rd != 0 && wb_rd == rs) return wb_result;
    return d;
  endfunction

  function automatic logic m_hazard();
    return m_valid && m_mr && m_rd != 0 && id_valid && (m_rd == id_rs1 || m_rd == id_rs2);
  endfunction

  task automatic compare();
    logic [31:0] a_exp;
    if (!m_init) return;
    chk("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
    chk("ex_aluop", {27'd0, ex_aluop}, {27'd0, m_aluop});
    chk("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m_rw});
    chk("ex_memread", {31'd0, ex_memread}, {31'd0, m_mr});
    chk("load_use_hazard", {31'd0, load_use_hazard}, {31'd0, m_hazard()});
    if (m_known) begin
      if (m_asel == 2'd0)      a_exp = m_fwd(m_rs1, m_d1);
      else if (m_asel == 2'd1) a_exp = m_pc;
      else                     a_exp = 32'd0;
      chk("ex_A", ex_A, a_exp);
      chk("ex_B", ex_B, m_bsel ? m_imm : m_fwd(m_rs2, m_d2));
      chk("ex_store_data", ex_store_data, m_fwd(m_rs2, m_d2));
      chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_rd});
    end
  endtask

  task automatic update();
    logic        hz;
    logic [31:0] f1, f2;
    hz = m_hazard();
    f1 = m_fwd(m_rs1, m_d1);
    f2 = m_fwd(m_rs2, m_d2);
    if (!rstn) begin
      m_init = 1'b1; m_known = 1'b1;
      m_valid = 0; m_rw = 0; m_mr = 0; m_bsel = 0; m_asel = 0;
      m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_aluop = 0;
      m_pc = 0; m_imm = 0; m_d1 = 0; m_d2 = 0;
    end else if (!m_init) begin
      // nothing known before the first reset
    end else if (flush || (!stall && hz)) begin
      m_valid = 0; m_aluop = 0; m_rw = 0; m_mr = 0; m_known = 0;
    end else if (stall) begin
      m_d1 = f1; m_d2 = f2;
    end else begin
      m_known = 1'b1;
      m_valid = id_valid;
      m_pc = id_pc; m_imm = id_imm; m_rd = id_rd;
      m_rs1 = id_rs1; m_rs2 = id_rs2;
      m_asel = id_asel; m_bsel = id_bsel;
      m_aluop = id_valid ? id_aluop : 5'd0;
      m_rw = id_valid && id_regwrite;
      m_mr = id_valid && id_memread;
      m_d1 = (wb_regwrite && wb_rd != 0 && wb_rd == id_rs1) ? wb_result : id_rs1_data;
      m_d2 = (wb_regwrite && wb_rd != 0 && wb_rd == id_rs2) ? wb_result : id_rs2_data;
    end
  endtask

  // Inputs change at posedge+1; checks and model step happen at the negedge.
  task automatic tick();
    #4;
    compare();
    update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rstn = 1; id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_aluop = 0; id_asel = 0; id_bsel = 0;
    id_regwrite = 0; id_memread = 0; stall = 0; flush = 0;
    mem_regwrite = 0; mem_rd = 0; mem_result = 0;
    wb_regwrite = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [31:0] d1, input logic [4:0] rs2,
                       input logic [31:0] d2, input logic [4:0] rd, input logic [4:0] op,
                       input logic [1:0] asel, input logic bsel, input logic memread);
    idle();
    id_valid = 1; id_rs1 = rs1; id_rs1_data = d1; id_rs2 = rs2; id_rs2_data = d2;
    id_rd = rd; id_aluop = op; id_asel = asel; id_bsel = bsel;
    id_regwrite = 1; id_memread = memread;
  endtask

  initial begin
    idle();
    // Reset with a live instruction presented.
    rstn = 0;
    issue(5'd1, 32'h11, 5'd2, 32'h22, 5'd3, ALU_ADD, 2'd0, 1'b0, 1'b0);
    rstn = 0;
    tick(); tick();
    idle(); #1;
    chk("reset_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_aluop", {27'd0, ex_aluop}, 32'd0);
    chk("reset_A", ex_A, 32'd0);
    chk("reset_B", ex_B, 32'd0);
    tick();

    // add x3,x1,x2 then MEM / WB forwarding on rs1.
    issue(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, ALU_ADD, 2'd0, 1'b0, 1'b0);
    tick();
    idle(); mem_regwrite = 1; mem_rd = 1; mem_result = 32'd100; #1;
    chk("memfwd_A", ex_A, 32'd100);
    chk("memfwd_B", ex_B, 32'd7);
    wb_regwrite = 1; wb_rd = 1; wb_result = 32'd50; #1;
    chk("mem_over_wb_A", ex_A, 32'd100);
    mem_regwrite = 0; #1;
    chk("wbfwd_A", ex_A, 32'd50);
    tick();

    // x0 is never forwarded.
    issue(5'd0, 32'd0, 5'd0, 32'd0, 5'd5, ALU_ADD, 2'd0, 1'b0, 1'b0);
    tick();
    idle(); mem_regwrite = 1; mem_rd = 0; mem_result = 32'hFFFF;
    wb_regwrite = 1; wb_rd = 0; wb_result = 32'hFFFF; #1;
    chk("x0_guard_A", ex_A, 32'd0);
    chk("x0_guard_store", ex_store_data, 32'd0);
    tick();

    // Load-use bubble.
    issue(5'd1, 32'd0, 5'd0, 32'd0, 5'd4, ALU_ADD, 2'd0, 1'b1, 1'b1);
    tick();
    issue(5'd5, 32'd1, 5'd4, 32'd2, 5'd6, ALU_ADD, 2'd0, 1'b0, 1'b0); #1;
    chk("loaduse_hazard", {31'd0, load_use_hazard}, 32'd1);
    tick();
    idle(); #1;
    chk("loaduse_valid", {31'd0, ex_valid}, 32'd0);
    chk("loaduse_aluop", {27'd0, ex_aluop}, 32'd0);
    tick();

    // Stall while the rs2 producer retires from WB.
    issue(5'd1, 32'd3, 5'd2, 32'd0, 5'd7, ALU_ADD, 2'd0, 1'b0, 1'b0);
    tick();
    idle(); stall = 1; wb_regwrite = 1; wb_rd = 2; wb_result = 32'd9; #1;
    chk("stall_fwd_B", ex_B, 32'd9);
    tick();
    idle(); #1;
    chk("stall_keep_B", ex_B, 32'd9);
    chk("stall_keep_valid", {31'd0, ex_valid}, 32'd1);
    tick();

    // Flush beats stall.
    issue(5'd1, 32'd1, 5'd2, 32'd2, 5'd8, ALU_ADD, 2'd0, 1'b0, 1'b0);
    tick();
    idle(); flush = 1; stall = 1;
    tick();
    idle(); #1;
    chk("flush_over_stall", {31'd0, ex_valid}, 32'd0);
    tick();

    // auipc operand select.
    issue(5'd0, 32'd0, 5'd0, 32'd0, 5'd9, ALU_AUIPC, 2'd1, 1'b1, 1'b0);
    id_pc = 32'h100; id_imm = 32'h2000;
    tick();
    idle(); #1;
    chk("auipc_A", ex_A, 32'h100);
    chk("auipc_B", ex_B, 32'h2000);
    chk("auipc_aluop", {27'd0, ex_aluop}, {27'd0, ALU_AUIPC});
    tick();

    // Randomized traffic on a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rstn         = ($urandom_range(0, 99) != 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_pc        = $urandom;
      id_rs1_data  = $urandom;
      id_rs2_data  = $urandom;
      id_imm       = $urandom;
      id_rs1       = 5'($urandom_range(0, 4));
      id_rs2       = 5'($urandom_range(0, 4));
      id_rd        = 5'($urandom_range(0, 4));
      id_aluop     = 5'($urandom_range(0, 31));
      id_asel      = 2'($urandom_range(0, 3));
      id_bsel      = 1'($urandom_range(0, 1));
      id_regwrite  = 1'($urandom_range(0, 1));
      id_memread   = ($urandom_range(0, 2) == 0);
      stall        = ($urandom_range(0, 6) == 0);
      flush        = ($urandom_range(0, 9) == 0);
      mem_regwrite = 1'($urandom_range(0, 1));
      mem_rd       = 5'($urandom_range(0, 4));
      mem_result   = $urandom;
      wb_regwrite  = 1'($urandom_range(0, 1));
      wb_rd        = 5'($urandom_range(0, 4));
      wb_result    = $urandom;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
